// File: rtl/atm_session_ctrl_pkg.sv
// Shared definitions for the ATM login session controller.
// Latency: n/a (types, constants and helpers only).
// Backpressure: n/a.
package atm_session_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_PIN = 2'd1,
    ST_CHECK    = 2'd2,
    ST_ACTIVE   = 2'd3
  } state_t;

  localparam int NUM_ACCOUNTS_DEF = 10;
  localparam int MAX_TRIES_DEF    = 3;

  function automatic logic [1:0] dec_sat(input logic [1:0] v);
    return (v == 2'd0) ? 2'd0 : v - 2'd1;
  endfunction

endpackage

// File: rtl/atm_session_ctrl_timeout_counter.sv
// Up-counter with synchronous reload, count enable and terminal-count flag.
// Latency: tc is combinational from the count; asserts in the LIMIT-th enabled cycle after a load.
// Backpressure: none; holds at terminal count until reloaded.
module atm_timeout_counter
  import atm_session_ctrl_pkg::*;
#(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic enable,
  output logic tc
);

  localparam int W = (LIMIT > 2) ? $clog2(LIMIT) : 1;
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (enable && (cnt != LAST)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc = enable && (cnt == LAST);

endmodule

// File: rtl/atm_session_ctrl.sv
// Sequences one ATM login: card check, PIN lookup via req/ack, try counting, lockout, idle abort.
// Latency: every output is registered and reacts one cycle after the triggering input.
// Backpressure: auth_req is held until auth_ack or AUTH_TO cycles; inputs outside their state are dropped.
module atm_session_ctrl
  import atm_session_ctrl_pkg::*;
#(
  parameter int NUM_ACCOUNTS = NUM_ACCOUNTS_DEF,
  parameter int ACC_W        = 4,
  parameter int PIN_W        = 16,
  parameter int MAX_TRIES    = MAX_TRIES_DEF,
  parameter int IDLE_TO      = 1000,
  parameter int AUTH_TO      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             card_in,
  input  logic [ACC_W-1:0] acc_num,
  input  logic             pin_valid,
  input  logic [PIN_W-1:0] pin,
  input  logic             logout,
  output logic             auth_req,
  output logic [ACC_W-1:0] auth_acc,
  output logic [PIN_W-1:0] auth_pin,
  input  logic             auth_ack,
  input  logic             auth_match,
  output logic             session_active,
  output logic [ACC_W-1:0] session_acc,
  output logic [1:0]       tries_left,
  output logic             pin_error,
  output logic             card_reject,
  output logic             locked_out
);

  state_t                  state;
  logic [ACC_W-1:0]        acc_r;
  logic [NUM_ACCOUNTS-1:0] lock;
  logic                    acc_ok;
  logic                    check_exit;
  logic                    idle_load, idle_en, idle_tc;
  logic                    auth_load, auth_en, auth_tc;

  // Out-of-range account numbers never match an index, so they are rejected too.
  always_comb begin
    acc_ok = 1'b0;
    for (int i = 0; i < NUM_ACCOUNTS; i++) begin
      if ((acc_num == ACC_W'(i)) && !lock[i]) acc_ok = 1'b1;
    end
  end

  assign check_exit = (state == ST_CHECK) && (logout || auth_ack || auth_tc);
  assign idle_load  = (state == ST_IDLE) || pin_valid || card_in || check_exit;
  assign idle_en    = (state == ST_WAIT_PIN) || (state == ST_ACTIVE);
  assign auth_load  = (state != ST_CHECK);
  assign auth_en    = (state == ST_CHECK);

  atm_timeout_counter #(.LIMIT(IDLE_TO)) u_idle_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (idle_load),
    .enable (idle_en),
    .tc     (idle_tc)
  );

  atm_timeout_counter #(.LIMIT(AUTH_TO)) u_auth_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (auth_load),
    .enable (auth_en),
    .tc     (auth_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      acc_r          <= '0;
      lock           <= '0;
      auth_req       <= 1'b0;
      auth_acc       <= '0;
      auth_pin       <= '0;
      session_active <= 1'b0;
      session_acc    <= '0;
      tries_left     <= 2'(MAX_TRIES);
      pin_error      <= 1'b0;
      card_reject    <= 1'b0;
      locked_out     <= 1'b0;
    end else begin
      pin_error   <= 1'b0;
      card_reject <= 1'b0;
      locked_out  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (card_in) begin
            if (acc_ok) begin
              acc_r      <= acc_num;
              tries_left <= 2'(MAX_TRIES);
              state      <= ST_WAIT_PIN;
            end else begin
              card_reject <= 1'b1;
            end
          end
        end
        ST_WAIT_PIN: begin
          if (logout) begin
            state <= ST_IDLE;
          end else if (pin_valid) begin
            auth_acc <= acc_r;
            auth_pin <= pin;
            auth_req <= 1'b1;
            state    <= ST_CHECK;
          end else if (idle_tc) begin
            state <= ST_IDLE;
          end
        end
        ST_CHECK: begin
          // logout wins over a same-cycle ack so an aborted lookup never costs a try
          if (logout) begin
            auth_req <= 1'b0;
            state    <= ST_IDLE;
          end else if (auth_ack) begin
            auth_req <= 1'b0;
            if (auth_match) begin
              session_active <= 1'b1;
              session_acc    <= acc_r;
              state          <= ST_ACTIVE;
            end else begin
              tries_left <= dec_sat(tries_left);
              pin_error  <= 1'b1;
              if (tries_left <= 2'd1) begin
                for (int i = 0; i < NUM_ACCOUNTS; i++) begin
                  if (acc_r == ACC_W'(i)) lock[i] <= 1'b1;
                end
                locked_out <= 1'b1;
                state      <= ST_IDLE;
              end else begin
                state <= ST_WAIT_PIN;
              end
            end
          end else if (auth_tc) begin
            auth_req  <= 1'b0;
            pin_error <= 1'b1;
            state     <= ST_WAIT_PIN;
          end
        end
        ST_ACTIVE: begin
          if (logout || idle_tc) begin
            session_active <= 1'b0;
            session_acc    <= '0;
            state          <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_atm_session_ctrl.sv
// Scoreboard bench: every expected output change is queued with its cycle; a monitor compares on each change.
module tb_atm_session_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        card_in = 1'b0;
  logic [3:0]  acc_num = '0;
  logic        pin_valid = 1'b0;
  logic [15:0] pin = '0;
  logic        logout = 1'b0;
  logic        auth_req;
  logic [3:0]  auth_acc;
  logic [15:0] auth_pin;
  logic        auth_ack = 1'b0;
  logic        auth_match = 1'b0;
  logic        session_active;
  logic [3:0]  session_acc;
  logic [1:0]  tries_left;
  logic        pin_error;
  logic        card_reject;
  logic        locked_out;

  atm_session_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .card_in        (card_in),
    .acc_num        (acc_num),
    .pin_valid      (pin_valid),
    .pin            (pin),
    .logout         (logout),
    .auth_req       (auth_req),
    .auth_acc       (auth_acc),
    .auth_pin       (auth_pin),
    .auth_ack       (auth_ack),
    .auth_match     (auth_match),
    .session_active (session_active),
    .session_acc    (session_acc),
    .tries_left     (tries_left),
    .pin_error      (pin_error),
    .card_reject    (card_reject),
    .locked_out     (locked_out)
  );

  typedef struct packed {
    logic        auth_req;
    logic [3:0]  auth_acc;
    logic [15:0] auth_pin;
    logic        session_active;
    logic [3:0]  session_acc;
    logic [1:0]  tries_left;
    logic        pin_error;
    logic        card_reject;
    logic        locked_out;
  } snap_t;

  typedef struct {
    snap_t s;
    int    cyc;   // -1: any cycle
  } exp_t;

  exp_t  exp_q[$];
  snap_t cur;
  snap_t mon_s;
  snap_t mon_prev = '1;
  int    cyc_cnt = 0;
  int    n_vec = 0;
  int    n_err = 0;
  logic  chk_now = 1'b0;
  logic  end_req = 1'b0;
  logic  end_done = 1'b0;
  int    k;

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  function automatic snap_t get_snap();
    snap_t s;
    s.auth_req       = auth_req;
    s.auth_acc       = auth_acc;
    s.auth_pin       = auth_pin;
    s.session_active = session_active;
    s.session_acc    = session_acc;
    s.tries_left     = tries_left;
    s.pin_error      = pin_error;
    s.card_reject    = card_reject;
    s.locked_out     = locked_out;
    return s;
  endfunction

  function automatic snap_t reset_snap();
    snap_t s;
    s            = '0;
    s.tries_left = 2'd3;
    return s;
  endfunction

  task automatic push(input int cyc);
    exp_t e;
    e.s   = cur;
    e.cyc = cyc;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic do_card(input logic [3:0] a);
    acc_num = a; card_in = 1'b1; tick(); card_in = 1'b0;
  endtask

  task automatic do_pin(input logic [15:0] p);
    pin = p; pin_valid = 1'b1; tick(); pin_valid = 1'b0;
  endtask

  task automatic do_ack(input logic m);
    auth_match = m; auth_ack = 1'b1; tick(); auth_ack = 1'b0;
  endtask

  task automatic do_logout();
    logout = 1'b1; tick(); logout = 1'b0;
  endtask

  // PIN accepted in WAIT_PIN: lookup request appears on the next edge
  task automatic pin_req(input logic [3:0] a, input logic [15:0] p);
    do_pin(p);
    cur.auth_req = 1'b1; cur.auth_acc = a; cur.auth_pin = p;
    push(cyc_cnt);
  endtask

  task automatic clear_pulses(input int at);
    cur.pin_error = 1'b0; cur.card_reject = 1'b0; cur.locked_out = 1'b0;
    push(at);
  endtask

  // Monitor: any change of the output snapshot is one observed response
  initial forever begin
    exp_t e;
    @(negedge clk or posedge chk_now or posedge end_req);
    if (end_req) begin
      if (!end_done) begin
        n_vec++;
        if (exp_q.size() != 0) begin
          n_err++;
          $display("FAIL pending_evts: %0d expected output changes never seen, required 0", exp_q.size());
        end
        end_done = 1'b1;
      end
    end else begin
      mon_s = get_snap();
      if (mon_s != mon_prev) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_evt: got %h at cyc %0d, required no output change", mon_s, cyc_cnt);
        end else begin
          e = exp_q.pop_front();
          if ((e.s != mon_s) || ((e.cyc >= 0) && (e.cyc != cyc_cnt))) begin
            n_err++;
            $display("FAIL out_evt: got %h at cyc %0d, required %h at cyc %0d", mon_s, cyc_cnt, e.s, e.cyc);
          end
        end
      end
      mon_prev = mon_s;
    end
  end

  initial begin
    cur = reset_snap();
    push(-1);
    #1 rst_n = 1'b0;
    #20 rst_n = 1'b1;
    idle(2);

    // 1: successful login on account 2
    do_card(4'd2);
    pin_req(4'd2, 16'd3456);
    idle(3);
    do_ack(1'b1);
    cur.auth_req = 1'b0; cur.session_active = 1'b1; cur.session_acc = 4'd2;
    push(cyc_cnt);
    idle(2);
    do_logout();
    cur.session_active = 1'b0; cur.session_acc = 4'd0;
    push(cyc_cnt);
    idle(2);

    // 2: three wrong PINs on account 5 lock it
    do_card(4'd5);
    for (int t = 0; t < 3; t++) begin
      pin_req(4'd5, 16'(1000 + t));
      idle(2);
      do_ack(1'b0);
      k = cyc_cnt;
      cur.auth_req   = 1'b0;
      cur.tries_left = 2'(2 - t);
      cur.pin_error  = 1'b1;
      cur.locked_out = (t == 2);
      push(k);
      clear_pulses(k + 1);
      idle(2);
    end
    do_card(4'd5);
    k = cyc_cnt;
    cur.card_reject = 1'b1;
    push(k);
    clear_pulses(k + 1);
    idle(2);

    // 3: out-of-range account; later PIN and ack must be ignored in IDLE
    do_card(4'd12);
    k = cyc_cnt;
    cur.card_reject = 1'b1;
    push(k);
    clear_pulses(k + 1);
    idle(3);
    do_pin(16'd1);
    do_ack(1'b1);
    idle(2);

    // 4: lookup with no ack times out after 16 cycles, no try consumed
    do_card(4'd1);
    cur.tries_left = 2'd3;
    push(cyc_cnt);
    pin_req(4'd1, 16'd4321);
    k = cyc_cnt;
    cur.auth_req = 1'b0; cur.pin_error = 1'b1;
    push(k + 16);
    clear_pulses(k + 17);
    idle(20);
    pin_req(4'd1, 16'd4321);
    idle(1);
    do_ack(1'b1);
    k = cyc_cnt;
    cur.auth_req = 1'b0; cur.session_active = 1'b1; cur.session_acc = 4'd1;
    push(k);

    // 5: idle timeout in ACTIVE, then logout racing auth_ack
    cur.session_active = 1'b0; cur.session_acc = 4'd0;
    push(k + 1000);
    idle(1005);
    do_card(4'd3);
    pin_req(4'd3, 16'd7777);
    idle(2);
    auth_match = 1'b0; auth_ack = 1'b1; logout = 1'b1;
    tick();
    auth_ack = 1'b0; logout = 1'b0;
    cur.auth_req = 1'b0;
    push(cyc_cnt);
    idle(3);
    do_pin(16'd9);
    idle(3);

    // 6: reset in the middle of a lookup clears outputs and the lock mask
    do_card(4'd7);
    pin_req(4'd7, 16'd2222);
    idle(2);
    @(posedge clk);
    #2 rst_n = 1'b0;
    cur = reset_snap();
    push(cyc_cnt);
    #1 chk_now = 1'b1;
    #1 chk_now = 1'b0;
    tick();
    rst_n = 1'b1;
    idle(2);
    do_card(4'd5);
    pin_req(4'd5, 16'd5555);
    idle(1);
    do_ack(1'b1);
    cur.auth_req = 1'b0; cur.session_active = 1'b1; cur.session_acc = 4'd5;
    push(cyc_cnt);
    idle(2);
    do_logout();
    cur.session_active = 1'b0; cur.session_acc = 4'd0;
    push(cyc_cnt);
    idle(5);

    end_req = 1'b1;
    wait (end_done);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
